// File: rtl/gpu_pixel_writer_pkg.sv
// Shared GPU definitions for the pixel writer: screen geometry, framebuffer
// word layout, the queue entry format and the address helper.
package gpu_pixel_writer_pkg;

  localparam int WIDTH_BITS    = 10;
  localparam int HEIGHT_BITS   = 9;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int FB_ADDR_BITS  = 19;
  localparam int COLOR_BITS    = 24;

  // One queued framebuffer write.
  typedef struct packed {
    logic [FB_ADDR_BITS-1:0] addr;
    logic [COLOR_BITS-1:0]   color;
  } px_entry_t;

  // Linear address y*640 + x built from shifts: 640 = 512 + 128.
  function automatic logic [FB_ADDR_BITS-1:0] pix_addr(
    input logic [WIDTH_BITS-1:0]  x,
    input logic [HEIGHT_BITS-1:0] y
  );
    logic [FB_ADDR_BITS-1:0] y_w;
    y_w = FB_ADDR_BITS'(y);
    return (y_w << 4'd9) + (y_w << 4'd7) + FB_ADDR_BITS'(x);
  endfunction

endpackage

// File: rtl/gpu_pixel_writer_if.sv
// Framebuffer write bus between the pixel writer (master) and memory (slave).
interface gpu_pixel_writer_if;
  import gpu_pixel_writer_pkg::*;

  logic                    mem_wr_o;
  logic [FB_ADDR_BITS-1:0] mem_addr_o;
  logic [COLOR_BITS-1:0]   mem_data_o;
  logic                    mem_ack_i;

  modport master (
    output mem_wr_o,
    output mem_addr_o,
    output mem_data_o,
    input  mem_ack_i
  );

  modport slave (
    input  mem_wr_o,
    input  mem_addr_o,
    input  mem_data_o,
    output mem_ack_i
  );

endinterface

// File: rtl/gpu_pixel_writer_fifo.sv
// Synchronous pixel queue. A push while full is accepted only together
// with a pop, so the count never exceeds DEPTH.
module gpu_pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 43
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write; entries need no reset because count gates their use.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Pixel writer: clips fill-engine pixels to the screen, queues on-screen
// ones and streams them to the framebuffer over a request/ack bus.
module gpu_pixel_writer
  import gpu_pixel_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   px_valid_i,
  input  logic [WIDTH_BITS-1:0]  X_i,
  input  logic [HEIGHT_BITS-1:0] Y_i,
  input  logic [COLOR_BITS-1:0]  color_i,
  input  logic                   done_i,
  output logic                   stall_o,
  gpu_pixel_writer_if.master     mem,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            clip_cnt_o,
  output logic                   ovf_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  px_entry_t        push_entry_s;
  px_entry_t        head_s;
  logic [$bits(px_entry_t)-1:0] fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] count_next_s;
  logic             on_screen_s;
  logic             pop_s;
  logic             accept_s;
  logic             push_s;
  logic             clip_s;
  logic             drop_s;
  logic             pend_eff_s;
  logic             fire_s;

  logic             stall_r;
  logic             busy_r;
  logic             done_r;
  logic             pending_r;
  logic [15:0]      clip_cnt_r;
  logic             ovf_r;

  gpu_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(px_entry_t))
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count_s)
  );

  assign head_s = fifo_dout_s;

  // Accept/clip/drop decisions and the queue occupancy after this cycle.
  always_comb begin
    on_screen_s  = (X_i < WIDTH_BITS'(SCREEN_WIDTH)) && (Y_i < HEIGHT_BITS'(SCREEN_HEIGHT));
    pop_s        = (state_r == ST_REQ) && mem.mem_ack_i && !fifo_empty_s;
    accept_s     = px_valid_i && (!fifo_full_s || pop_s);
    push_s       = accept_s && on_screen_s;
    clip_s       = accept_s && !on_screen_s;
    drop_s       = px_valid_i && !accept_s;
    push_entry_s = '{addr: pix_addr(X_i, Y_i), color: color_i};
    count_next_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Next-state logic; leaving IDLE on the push itself gives one-cycle latency.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (count_next_s != {CNT_W{1'b0}}) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (pop_s && (count_next_s == {CNT_W{1'b0}})) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Shape-complete detection: a done seen now or earlier, with nothing left to write.
  always_comb begin
    pend_eff_s = pending_r || done_i;
    fire_s     = pend_eff_s && (count_next_s == {CNT_W{1'b0}}) && (state_next_s == ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered status outputs, done tracking and error counters.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pending_r  <= 1'b0;
      clip_cnt_r <= 16'h0000;
      ovf_r      <= 1'b0;
    end else begin
      stall_r   <= (count_next_s >= CNT_W'(FIFO_DEPTH - 1));
      busy_r    <= (count_next_s != {CNT_W{1'b0}}) || (state_next_s == ST_REQ);
      done_r    <= fire_s;
      pending_r <= pend_eff_s && !fire_s;
      if (clip_s && (clip_cnt_r != 16'hFFFF)) begin
        clip_cnt_r <= clip_cnt_r + 16'h0001;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Bus is driven from the state flop and the queue head; zero whenever idle.
  assign mem.mem_wr_o   = (state_r == ST_REQ);
  assign mem.mem_addr_o = (state_r == ST_REQ) ? head_s.addr  : {FB_ADDR_BITS{1'b0}};
  assign mem.mem_data_o = (state_r == ST_REQ) ? head_s.color : {COLOR_BITS{1'b0}};

  assign stall_o    = stall_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign clip_cnt_o = clip_cnt_r;
  assign ovf_o      = ovf_r;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed bench for gpu_pixel_writer with a write scoreboard and monitor.
module tb_gpu_pixel_writer;
  import gpu_pixel_writer_pkg::*;

  logic                   clk = 1'b0;
  logic                   n_rst;
  logic                   px_valid_i;
  logic [WIDTH_BITS-1:0]  X_i;
  logic [HEIGHT_BITS-1:0] Y_i;
  logic [COLOR_BITS-1:0]  color_i;
  logic                   done_i;
  logic                   stall_o;
  logic                   busy_o;
  logic                   done_o;
  logic [15:0]            clip_cnt_o;
  logic                   ovf_o;

  gpu_pixel_writer_if mem_if ();

  gpu_pixel_writer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .px_valid_i (px_valid_i),
    .X_i        (X_i),
    .Y_i        (Y_i),
    .color_i    (color_i),
    .done_i     (done_i),
    .stall_o    (stall_o),
    .mem        (mem_if.master),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .clip_cnt_o (clip_cnt_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int writes_seen = 0;
  int done_seen   = 0;
  logic [42:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pixel for a single cycle; queue the expected write if it should land.
  task automatic send(input int x, input int y, input logic [23:0] c, input bit expect_wr);
    px_valid_i = 1'b1;
    X_i        = WIDTH_BITS'(x);
    Y_i        = HEIGHT_BITS'(y);
    color_i    = c;
    if (expect_wr) sb.push_back({19'(y * 640 + x), c});
    @(posedge clk);
    #1;
    px_valid_i = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o !== 1'b0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, sb.size(), 0);
    chk({name, "_idle"}, 32'(busy_o), 0);
  endtask

  // Monitor: checks every accepted write against the scoreboard and hold stability.
  initial begin : monitor
    logic        held;
    logic [18:0] h_addr;
    logic [23:0] h_data;
    logic [42:0] e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (n_rst !== 1'b1) begin
        held = 1'b0;
      end else begin
        if (done_o === 1'b1) done_seen++;
        if (held) begin
          chk("hold_wr",   32'(mem_if.mem_wr_o), 1);
          chk("hold_addr", 32'(mem_if.mem_addr_o), 32'(h_addr));
          chk("hold_data", 32'(mem_if.mem_data_o), 32'(h_data));
        end
        if (mem_if.mem_wr_o === 1'b1 && mem_if.mem_ack_i === 1'b1) begin
          writes_seen++;
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h while none was expected",
                     mem_if.mem_addr_o, mem_if.mem_data_o);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(mem_if.mem_addr_o), 32'(e[42:24]));
            chk("wr_data", 32'(mem_if.mem_data_o), 32'(e[23:0]));
          end
        end
        held   = (mem_if.mem_wr_o === 1'b1 && mem_if.mem_ack_i === 1'b0);
        h_addr = mem_if.mem_addr_o;
        h_data = mem_if.mem_data_o;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w0;
    int d0;
    int xq[$];
    int yq[$];
    int cx, cy, r, xx, yy, dd, cyc;
    bit sent;

    n_rst            = 1'b0;
    px_valid_i       = 1'b0;
    X_i              = '0;
    Y_i              = '0;
    color_i          = '0;
    done_i           = 1'b0;
    mem_if.mem_ack_i = 1'b0;

    // Reset state
    #2;
    chk("rst_wr",    32'(mem_if.mem_wr_o), 0);
    chk("rst_addr",  32'(mem_if.mem_addr_o), 0);
    chk("rst_data",  32'(mem_if.mem_data_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_done",  32'(done_o), 0);
    chk("rst_clip",  32'(clip_cnt_o), 0);
    chk("rst_ovf",   32'(ovf_o), 0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick(1);

    // Single pixel, ack tied high, then done
    mem_if.mem_ack_i = 1'b1;
    send(320, 240, 24'hFFFFFF, 1'b1);
    chk("lat_wr",   32'(mem_if.mem_wr_o), 1);
    chk("lat_addr", 32'(mem_if.mem_addr_o), 153920);
    chk("lat_busy", 32'(busy_o), 1);
    done_i = 1'b1;
    @(posedge clk);
    #1;
    done_i = 1'b0;
    chk("done_pulse",   32'(done_o), 1);
    chk("done_wr_idle", 32'(mem_if.mem_wr_o), 0);
    tick(1);
    chk("done_one_cycle", 32'(done_o), 0);
    chk("single_sb", sb.size(), 0);

    // Clipping
    w0 = writes_seen;
    send(640, 0,   24'h111111, 1'b0);
    send(0,   480, 24'h222222, 1'b0);
    send(639, 479, 24'h123456, 1'b1);
    drain("clip", 50);
    chk("clip_cnt",    32'(clip_cnt_o), 2);
    chk("clip_writes", writes_seen - w0, 1);

    // Backpressure
    mem_if.mem_ack_i = 1'b0;
    w0 = writes_seen;
    send(0,  0, 24'h0000AA, 1'b1);
    send(1,  0, 24'h0000BB, 1'b1);
    chk("stall_after2", 32'(stall_o), 0);
    send(10, 5, 24'h0000CC, 1'b1);
    chk("stall_after3", 32'(stall_o), 1);
    chk("bp_wr_held",   32'(mem_if.mem_wr_o), 1);
    chk("bp_addr_head", 32'(mem_if.mem_addr_o), 0);
    tick(3);
    chk("bp_no_write", writes_seen - w0, 0);
    mem_if.mem_ack_i = 1'b1;
    drain("bp", 50);
    chk("bp_writes",    writes_seen - w0, 3);
    chk("bp_stall_off", 32'(stall_o), 0);

    // Overflow: six pixels into a four-deep queue with ack low
    mem_if.mem_ack_i = 1'b0;
    w0 = writes_seen;
    for (int i = 0; i < 6; i++) begin
      send(i * 7, 100, 24'(24'hA00000 + i), (i < 4));
    end
    chk("ovf_set",   32'(ovf_o), 1);
    chk("ovf_stall", 32'(stall_o), 1);
    mem_if.mem_ack_i = 1'b1;
    drain("ovf", 50);
    chk("ovf_writes", writes_seen - w0, 4);
    chk("ovf_sticky", 32'(ovf_o), 1);

    // Reset in the middle of a write with a done pending
    mem_if.mem_ack_i = 1'b0;
    w0 = writes_seen;
    d0 = done_seen;
    send(5, 5, 24'h0F0F0F, 1'b1);
    done_i = 1'b1;
    @(posedge clk);
    #1;
    done_i = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    chk("mr_wr",    32'(mem_if.mem_wr_o), 0);
    chk("mr_addr",  32'(mem_if.mem_addr_o), 0);
    chk("mr_data",  32'(mem_if.mem_data_o), 0);
    chk("mr_busy",  32'(busy_o), 0);
    chk("mr_stall", 32'(stall_o), 0);
    chk("mr_clip",  32'(clip_cnt_o), 0);
    chk("mr_ovf",   32'(ovf_o), 0);
    chk("mr_done",  32'(done_o), 0);
    sb.delete();
    tick(2);
    n_rst = 1'b1;
    mem_if.mem_ack_i = 1'b1;
    tick(10);
    chk("mr_no_done",  done_seen - d0, 0);
    chk("mr_no_write", writes_seen - w0, 0);
    chk("mr_idle",     32'(busy_o), 0);

    // Streaming a rad-200 circle outline with random ack, honouring stall
    cx = 320; cy = 240; r = 200;
    xx = 0; yy = r; dd = 1 - r;
    while (xx <= yy) begin
      xq.push_back(cx + xx); yq.push_back(cy + yy);
      xq.push_back(cx - xx); yq.push_back(cy + yy);
      xq.push_back(cx + xx); yq.push_back(cy - yy);
      xq.push_back(cx - xx); yq.push_back(cy - yy);
      xq.push_back(cx + yy); yq.push_back(cy + xx);
      xq.push_back(cx - yy); yq.push_back(cy + xx);
      xq.push_back(cx + yy); yq.push_back(cy - xx);
      xq.push_back(cx - yy); yq.push_back(cy - xx);
      if (dd < 0) begin
        dd = dd + 2 * xx + 3;
      end else begin
        dd = dd + 2 * (xx - yy) + 5;
        yy = yy - 1;
      end
      xx = xx + 1;
    end
    w0  = writes_seen;
    d0  = done_seen;
    cyc = 0;
    for (int i = 0; i < xq.size(); i++) begin
      sent = 1'b0;
      while (!sent && cyc < 20000) begin
        mem_if.mem_ack_i = 1'($urandom_range(0, 1));
        if (stall_o === 1'b0) begin
          px_valid_i = 1'b1;
          X_i        = WIDTH_BITS'(xq[i]);
          Y_i        = HEIGHT_BITS'(yq[i]);
          color_i    = 24'(i) ^ 24'h5A5A5A;
          sb.push_back({19'(yq[i] * 640 + xq[i]), 24'(i) ^ 24'h5A5A5A});
          sent = 1'b1;
        end else begin
          px_valid_i = 1'b0;
        end
        @(posedge clk);
        #1;
        px_valid_i = 1'b0;
        cyc++;
      end
    end
    chk("stream_no_timeout", 32'(cyc < 20000), 1);
    done_i = 1'b1;
    mem_if.mem_ack_i = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    done_i = 1'b0;
    cyc = 0;
    while (done_seen == d0 && cyc < 2000) begin
      mem_if.mem_ack_i = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cyc++;
    end
    mem_if.mem_ack_i = 1'b1;
    drain("stream", 50);
    tick(5);
    chk("stream_writes", writes_seen - w0, xq.size());
    chk("stream_done",   done_seen - d0, 1);
    chk("stream_ovf",    32'(ovf_o), 0);
    chk("stream_clip",   32'(clip_cnt_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpu_pixel_writer.md
GPU_PIXEL_WRITER -- requirements
Module: gpu_pixel_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the pixel queue depth in entries (power of two, >=4).
REQ-002 SHALL have port clk, input, 1, meaning the system clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port px_valid_i, input, 1, meaning the fill engine presents a pixel this cycle (driven from the engine's busy_o).
REQ-005 SHALL have port X_i, input, WIDTH_BITS, meaning the pixel column.
REQ-006 SHALL have port Y_i, input, HEIGHT_BITS, meaning the pixel row.
REQ-007 SHALL have port color_i, input, 24, meaning RGB888 colour {r,g,b}, sampled with the pixel.
REQ-008 SHALL have port done_i, input, 1, meaning a one-cycle pulse from the fill engine marking the end of the shape.
REQ-009 SHALL have port stall_o, output, 1, meaning the queue is almost full; the producer holds its pixel.
REQ-010 SHALL have port mem_wr_o, output, 1, meaning a framebuffer write request.
REQ-011 SHALL have port mem_addr_o, output, 19, meaning the framebuffer word address.
REQ-012 SHALL have port mem_data_o, output, 24, meaning the framebuffer write data.
REQ-013 SHALL have port mem_ack_i, input, 1, meaning the framebuffer accepted the current write.
REQ-014 SHALL have port busy_o, output, 1, meaning the queue is non-empty or a write is outstanding.
REQ-015 SHALL have port done_o, output, 1, meaning a one-cycle pulse when the shape is fully written.
REQ-016 SHALL have port clip_cnt_o, output, 16, meaning the saturating count of off-screen pixels discarded.
REQ-017 SHALL have port ovf_o, output, 1, meaning sticky: a pixel was dropped because the queue was full.

Function
REQ-018 SHALL accept a pixel in any cycle where px_valid_i=1 and the queue is not full.
REQ-019 SHALL discard any accepted pixel with X_i>=SCREEN_WIDTH (640) or Y_i>=SCREEN_HEIGHT (480), and SHALL increment clip_cnt_o for it, saturating at 16'hFFFF.
REQ-020 SHALL push each on-screen pixel into the queue as {addr = Y_i*640 + X_i (19 bits, computed as (Y<<9)+(Y<<7)+X, no multiplier), color_i}.
REQ-021 SHALL register stall_o high when the queue count after this cycle's push and pop is >= FIFO_DEPTH-1, giving the producer one cycle of slack.
REQ-022 SHALL drop a pixel presented while the queue is full, and SHALL set ovf_o, which stays set until reset.
REQ-023 SHALL implement an FSM with state IDLE: mem_wr_o=0; go to REQ when the queue is non-empty.
REQ-024 SHALL, in state REQ, hold mem_wr_o=1 with mem_addr_o and mem_data_o stable, from the queue head, until mem_ack_i=1.
REQ-025 SHALL, on mem_ack_i=1 in REQ, pop the head; it SHALL stay in REQ presenting the next entry on the following cycle if one exists, else return to IDLE.
REQ-026 SHALL ignore mem_ack_i while in IDLE.
REQ-027 SHALL have a latency of one cycle: a pixel accepted in cycle N with the queue empty and FSM idle appears on mem_wr_o in cycle N+1.
REQ-028 SHALL give the maximum throughput of one write per cycle when mem_ack_i is held high.
REQ-029 SHALL allow a push and a pop in the same cycle; the count is unchanged, and this SHALL be legal when the queue is full.
REQ-030 SHALL latch done_i as pending, and SHALL pulse done_o for one cycle in the first cycle that pending=1, the queue is empty and the FSM is IDLE; pending then clears.
REQ-031 SHALL, when done_i coincides with a valid pixel, accept the pixel before the done is considered.
REQ-032 SHALL drive busy_o = (queue non-empty) OR (state==REQ), registered.

Reset
REQ-033 SHALL, on n_rst=0, asynchronously clear the FSM to IDLE, the queue pointers and count, pending, clip_cnt_o and ovf_o.
REQ-034 SHALL hold mem_wr_o=0, mem_addr_o=0, mem_data_o=0, stall_o=0, busy_o=0 and done_o=0 during reset.
REQ-035 SHALL abandon any in-flight write on reset mid-operation, with no completion or done_o afterwards.

Structure
REQ-036 SHALL take WIDTH_BITS, HEIGHT_BITS, SCREEN_WIDTH=640, SCREEN_HEIGHT=480, FB_ADDR_BITS=19 and COLOR_BITS=24 from the shared gpu_definitions header; the FSM state encoding SHALL be local.
REQ-037 SHALL place the queue in one sub-module, gpu_pixel_fifo (synchronous FIFO with push/pop/full/empty/count), instantiated once.

Verification
REQ-038 SHALL verify single pixel (X=320, Y=240, color=24'hFFFFFF), mem_ack_i tied 1 -> one write, addr=153920, data=FFFFFF, next cycle after accept; done_i then gives done_o 1 cycle after the write.
REQ-039 SHALL verify clipping: pixels (640,0), (0,480), (639,479) -> only addr=307199 written; clip_cnt_o=2.
REQ-040 SHALL verify backpressure: mem_ack_i=0 while 3 pixels are sent -> stall_o=1 after the 3rd; releasing ack gives 3 writes in order with addresses held stable while unacked.
REQ-041 SHALL verify overflow: ignore stall_o and push 6 pixels with ack low -> ovf_o=1 and exactly 4 writes after the ack is released.
REQ-042 SHALL verify streaming: the fill engine output for a circle at centre (320,240), rad 200 is consumed with random ack -> every in-range pixel is written exactly once, one done_o, ovf_o=0.
REQ-043 SHALL verify mid-operation reset: assert n_rst while in REQ -> mem_wr_o=0 immediately, all counters 0, and no done_o afterwards.
